// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: tagged fetch buffer between the core ROM port and a req/gnt/rvalid bus.
// Define FETCH_PREFETCH_EN for a 2-entry buffer with next-word prefetch after each demand fill.
module inst_fetch_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        stallreq_o,
  input  logic        inv_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);
`ifdef FETCH_PREFETCH_EN
  localparam int N = 2;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, PREQ, PWAIT} state_t;
`else
  localparam int N = 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
`endif
  state_t state, state_nxt;
  logic [N-1:0] valid, match;
  logic [29:0] tag [N];
  logic [31:0] data [N];
  logic [29:0] req_tag;
  logic [7:0] cnt;
  logic drop, hit, miss, waiting, requesting, rsp, tmo, store, widx, pf_go;
  logic [31:0] hit_data;
  for (genvar g = 0; g < N; g++) begin : g_match
    assign match[g] = valid[g] && tag[g] == rom_addr_i[31:2];
  end
  always_comb begin
    hit_data = NOP_INST;
    for (int i = 0; i < N; i++) if (match[i]) hit_data = data[i];
  end
  assign hit = rom_ce_i && |match;
  assign miss = rom_ce_i && !hit;
  assign rom_data_o = hit ? hit_data : NOP_INST;
  assign stallreq_o = rst && miss;
`ifdef FETCH_PREFETCH_EN
  logic rr;
  assign widx = rr;
  assign requesting = state == REQ || state == PREQ;
  assign waiting = state == WAIT || state == PWAIT;
  // the demand fill lands in entry rr, so only the other entry can already hold T+1
  assign pf_go = state == WAIT && mem_rvalid_i && store && !(valid[~rr] && tag[~rr] == req_tag + 30'd1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) rr <= 1'b0;
    else if (store) rr <= ~rr;
`else
  assign widx = 1'b0;
  assign requesting = state == REQ;
  assign waiting = state == WAIT;
  assign pf_go = 1'b0;
`endif
  assign rsp = waiting && mem_rvalid_i;
  assign tmo = waiting && !mem_rvalid_i && cnt == 8'(TIMEOUT_CYC - 1);
  assign err_o = state == WAIT && tmo;
  // a prefetch timeout stores nothing; a demand timeout stores NOP under the tag
  assign store = !inv_i && !drop && (rsp || (state == WAIT && tmo));
  assign mem_req_o = requesting;
  assign mem_addr_o = {req_tag, 2'b00};
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = miss ? REQ : IDLE;
      REQ: state_nxt = mem_gnt_i ? WAIT : REQ;
`ifdef FETCH_PREFETCH_EN
      WAIT: state_nxt = pf_go ? PREQ : (rsp || tmo) ? IDLE : WAIT;
      PREQ: state_nxt = mem_gnt_i ? PWAIT : PREQ;
      PWAIT: state_nxt = (rsp || tmo) ? IDLE : PWAIT;
`else
      WAIT: state_nxt = (rsp || tmo) ? IDLE : WAIT;
`endif
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      valid <= '0;
      req_tag <= '0;
      cnt <= '0;
      drop <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= (waiting && state_nxt == state) ? cnt + 8'd1 : 8'd0;
      drop <= state_nxt != IDLE && (drop || (inv_i && state != IDLE));
      if (state == IDLE && miss) req_tag <= rom_addr_i[31:2];
      else if (pf_go) req_tag <= req_tag + 30'd1;
      if (inv_i) valid <= '0;
      else if (store) valid[widx] <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (store) begin
      tag[widx] <= req_tag;
      data[widx] <= mem_rvalid_i ? mem_rdata_i : NOP_INST;
    end
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb_inst_fetch_bridge: directed corner cases plus randomized fetches checked against
// a memory-content function and a one-entry "last filled word" cache model.
module tb_inst_fetch_bridge;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  logic clk = 0, rst = 0, rom_ce_i = 0, inv_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [31:0] rom_addr_i = 0, mem_rdata_i = 0, rom_data_o, mem_addr_o;
  logic stallreq_o, mem_req_o, err_o;
  int n_chk = 0, n_fail = 0, n;
  bit mv = 0;
  logic [29:0] mtag = 0;
  logic [31:0] a;
  logic [31:0] pool [6] = '{32'h100, 32'h104, 32'h2000, 32'h2004, 32'h3FC, 32'hFFFF_FFFC};
  inst_fetch_bridge #(.TIMEOUT_CYC(8), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
    .stallreq_o(stallreq_o), .inv_i(inv_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [31:0] mem_word(input logic [31:0] x);
    return {x[31:2], 2'b01} ^ 32'hC3A5_0F00;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // plays the memory: waits for req, grants after gw cycles, returns data in WAIT cycle rw
  task automatic bus(input logic [31:0] ad, input bit ck, input int gw, input int rw,
                     input logic [31:0] d, input bit rv, input bit iv);
    int k = 0;
    logic [31:0] dd;
    while (!mem_req_o && k < 20) begin @(negedge clk); #1; k++; end
    chk("bus_req", {31'b0, mem_req_o}, 1);
    if (ck) chk("bus_addr", mem_addr_o, ad);
    dd = ck ? d : mem_word(mem_addr_o);
    repeat (gw) begin
      @(negedge clk); #1;
      chk("bus_hold_req", {31'b0, mem_req_o}, 1);
      if (ck) chk("bus_hold_addr", mem_addr_o, ad);
    end
    mem_gnt_i = 1;
    @(negedge clk); mem_gnt_i = 0;
    if (rv) begin
      repeat (rw - 1) @(negedge clk);
      mem_rvalid_i = 1; mem_rdata_i = dd; inv_i = iv;
      @(negedge clk); mem_rvalid_i = 0; inv_i = 0;
      if (iv) mv = 0;
      else if (ck) begin mv = 1; mtag = ad[31:2]; end
    end
    #1;
  endtask
  task automatic after_fill(input logic [31:0] ad);
`ifdef FETCH_PREFETCH_EN
    bus(ad + 32'd4, 1, 0, 1, mem_word(ad + 32'd4), 1, 0);
`else
    chk("no_prefetch", {31'b0, mem_req_o}, 0);
    chk("fill_addr", mem_addr_o, ad);
`endif
  endtask
  initial begin
    rom_ce_i = 1; rom_addr_i = 32'h100;
    @(negedge clk); #1;
    chk("rst_stall", {31'b0, stallreq_o}, 0);
    chk("rst_req", {31'b0, mem_req_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_err", {31'b0, err_o}, 0);
    chk("rst_data", rom_data_o, NOP);
    @(negedge clk); rst = 1; rom_ce_i = 0;
    // cold miss
    @(negedge clk); rom_ce_i = 1; rom_addr_i = 32'h100; #1;
    chk("miss_stall", {31'b0, stallreq_o}, 1);
    chk("miss_data", rom_data_o, NOP);
    bus(32'h100, 1, 1, 3, 32'h3C01_1234, 1, 0);
    chk("fill_stall", {31'b0, stallreq_o}, 0);
    chk("fill_data", rom_data_o, 32'h3C01_1234);
    after_fill(32'h100);
    // hit, low address bits ignored
    @(negedge clk); rom_addr_i = 32'h102; #1;
    chk("hit_stall", {31'b0, stallreq_o}, 0);
    chk("hit_data", rom_data_o, 32'h3C01_1234);
    @(negedge clk); #1;
    chk("hit_noreq", {31'b0, mem_req_o}, 0);
    // rom_ce low on an uncached address
    @(negedge clk); rom_ce_i = 0; rom_addr_i = 32'h7000; #1;
    chk("ce0_data", rom_data_o, NOP);
    chk("ce0_stall", {31'b0, stallreq_o}, 0);
    @(negedge clk); #1;
    chk("ce0_noreq", {31'b0, mem_req_o}, 0);
    // timeout
    @(negedge clk); rom_ce_i = 1; rom_addr_i = 32'h300; #1;
    bus(32'h300, 1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("tmo_err_c%0d", k), {31'b0, err_o}, {31'b0, k == 8});
      if (k < 8) begin @(negedge clk); #1; end
    end
    @(negedge clk); #1;
    chk("tmo_err_after", {31'b0, err_o}, 0);
    chk("tmo_stall", {31'b0, stallreq_o}, 0);
    chk("tmo_data", rom_data_o, NOP);
    @(negedge clk); mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk); mem_rvalid_i = 0; #1;
    chk("late_rv_data", rom_data_o, NOP);
    chk("late_rv_err", {31'b0, err_o}, 0);
    chk("late_rv_req", {31'b0, mem_req_o}, 0);
    // invalidate coinciding with rvalid
    @(negedge clk); rom_addr_i = 32'h200; #1;
    bus(32'h200, 1, 0, 2, 32'h1111_0200, 1, 1);
    chk("inv_stall", {31'b0, stallreq_o}, 1);
    chk("inv_data", rom_data_o, NOP);
    bus(32'h200, 1, 0, 1, 32'h2222_0200, 1, 0);
    chk("refill_data", rom_data_o, 32'h2222_0200);
    after_fill(32'h200);
    // reset while waiting, rvalid during and right after reset
    @(negedge clk); rom_addr_i = 32'h400; #1;
    bus(32'h400, 1, 0, 1, 0, 0, 0);
    @(negedge clk); #1;
    @(negedge clk); rst = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0_0400; #1;
    chk("mrst_stall", {31'b0, stallreq_o}, 0);
    chk("mrst_req", {31'b0, mem_req_o}, 0);
    chk("mrst_addr", mem_addr_o, 0);
    chk("mrst_data", rom_data_o, NOP);
    @(negedge clk); #1;
    chk("mrst_err", {31'b0, err_o}, 0);
    @(negedge clk); rst = 1; #1;
    mv = 0;
    chk("prst_stall", {31'b0, stallreq_o}, 1);
    chk("prst_data", rom_data_o, NOP);
    @(negedge clk); mem_rvalid_i = 0; #1;
    chk("prst_nostore", {31'b0, stallreq_o}, 1);
    bus(32'h400, 1, 0, 2, 32'h0400_CAFE, 1, 0);
    chk("prst_fill", rom_data_o, 32'h0400_CAFE);
    after_fill(32'h400);
`ifdef FETCH_PREFETCH_EN
    // prefetch wraps from the top word to address 0
    @(negedge clk); inv_i = 1; rom_ce_i = 0;
    @(negedge clk); inv_i = 0; rom_ce_i = 1; rom_addr_i = 32'hFFFF_FFFC; #1;
    bus(32'hFFFF_FFFC, 1, 0, 2, 32'hA5A5_0001, 1, 0);
    chk("pf_top_data", rom_data_o, 32'hA5A5_0001);
    bus(32'h0, 1, 0, 1, 32'h1357_9BDF, 1, 0);
    @(negedge clk); rom_addr_i = 32'h0; #1;
    chk("pf_zero_stall", {31'b0, stallreq_o}, 0);
    chk("pf_zero_data", rom_data_o, 32'h1357_9BDF);
    chk("pf_zero_noreq", {31'b0, mem_req_o}, 0);
`endif
    // randomized fetches
    @(negedge clk); inv_i = 1; rom_ce_i = 0;
    @(negedge clk); inv_i = 0; mv = 0;
    for (int it = 0; it < 60; it++) begin
      a = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk); rom_ce_i = 0; rom_addr_i = a; #1;
        chk("rnd_ce0_data", rom_data_o, NOP);
        chk("rnd_ce0_stall", {31'b0, stallreq_o}, 0);
      end
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk); inv_i = 1; rom_ce_i = 0;
        @(negedge clk); inv_i = 0; mv = 0;
      end
      @(negedge clk); rom_ce_i = 1; rom_addr_i = a; #1;
`ifndef FETCH_PREFETCH_EN
      chk("rnd_hit", {31'b0, !stallreq_o}, {31'b0, mv && mtag == a[31:2]});
`endif
      n = 0;
      while (stallreq_o && n < 40) begin
        if (mem_req_o) bus({a[31:2], 2'b00}, !PF, $urandom_range(0, 2), $urandom_range(1, 5), mem_word(a), 1, 0);
        else begin @(negedge clk); #1; end
        n++;
      end
      chk("rnd_stall", {31'b0, stallreq_o}, 0);
      chk("rnd_data", rom_data_o, mem_word(a));
    end
    n = 0;
    while (mem_req_o && n < 4) begin bus(0, 0, 0, 1, 0, 1, 0); n++; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
